// File: rtl/aes_core_iter.sv
// aes_core_iter: iterative AES-128/192/256 encryption core (FIPS-197).
// One round is computed per clock through a single shared round datapath.
// The key schedule is produced on the fly from a sliding window of NK words,
// so the expanded schedule is never stored.
//
// Parameters:
//   KEY_BITS   key length in bits; 128, 192 or 256 only
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers a plaintext block and key
//   in_ready   core is idle and will accept a block on this edge
//   state      128-bit plaintext, bit 127 = first FIPS-197 byte
//   key        KEY_BITS cipher key, MSB = first FIPS-197 key byte
//   out_valid  ciphertext on out is valid (held until out_ready)
//   out_ready  downstream accepts the ciphertext
//   out        128-bit ciphertext, same byte order as state
//   busy       a block is in flight or waiting to be taken
module aes_core_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        state,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out,
  output logic                busy
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t                fsm;
  logic [127:0]        data_q;
  logic [KEY_BITS-1:0] win_q;
  logic [3:0]          round_q;
  logic [7:0]          rcon_q;
  logic [2:0]          phase_q;

  logic [127:0]        round_key;
  logic [127:0]        round_out;
  logic [KEY_BITS-1:0] win_next;
  logic [7:0]          rcon_next;
  logic [2:0]          phase_next;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    end
    return r;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Key window step. win_q holds words w[b .. b+NK-1] with b = 4*(round-1).
  // Four further words are derived each cycle; the round key is window
  // words 4..7 and the window then slides forward by four words.
  // phase_q tracks b mod NK so we know which new word takes
  // RotWord/SubWord/Rcon (and, for 256-bit keys, the extra plain SubWord).
  always_comb begin
    logic [31:0] ext [NK+4];
    logic [31:0] t;
    logic [7:0]  rc;
    int          p;
    rc = rcon_q;
    for (int k = 0; k < NK; k++) begin
      ext[k] = win_q[KEY_BITS-1-32*k -: 32];
    end
    for (int j = 0; j < 4; j++) begin
      p = int'(phase_q) + j;
      if (p >= NK) begin
        p = p - NK;
      end
      t = ext[NK+j-1];
      if (p == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (NK == 8 && p == 4) begin
        t = sub_word(t);
      end
      ext[NK+j] = ext[j] ^ t;
    end
    round_key = {ext[4], ext[5], ext[6], ext[7]};
    win_next  = '0;
    for (int k = 0; k < NK; k++) begin
      win_next[KEY_BITS-1-32*k -: 32] = ext[4+k];
    end
    rcon_next  = rc;
    phase_next = (int'(phase_q) + 4 >= NK) ? 3'(int'(phase_q) + 4 - NK)
                                           : 3'(int'(phase_q) + 4);
  end

  // Shared round datapath; the final round skips MixColumns.
  always_comb begin
    logic [127:0] shifted;
    shifted   = shift_rows(sub_bytes(data_q));
    round_out = ((round_q == LAST_ROUND) ? shifted : mix_columns(shifted))
                ^ round_key;
  end

  // Control FSM with registered handshake outputs. Inputs are only looked at
  // in IDLE, so anything upstream does mid-block cannot disturb the block in
  // flight. The round counter stops at NR and the last ciphertext stays on
  // out until the next completion overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= '0;
      round_q   <= '0;
      data_q    <= '0;
      win_q     <= '0;
      rcon_q    <= 8'h01;
      phase_q   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            data_q   <= state ^ key[KEY_BITS-1 -: 128];
            win_q    <= key;
            round_q  <= 4'd1;
            rcon_q   <= 8'h01;
            phase_q  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          data_q  <= round_out;
          win_q   <= win_next;
          rcon_q  <= rcon_next;
          phase_q <= phase_next;
          if (round_q == LAST_ROUND) begin
            out       <= round_out;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule
